axi_burst_mem_slave: RTL and testbench

AXI4 full-protocol responder backed by an on-chip word memory. It is the target the `AXI_master` burst engine is pointed at in simulation and in loopback builds. It accepts INCR write and read bursts of 1–256 beats, stores and returns data with byte strobes, and reports OKAY or SLVERR per burst. The write and read channels are independent and can run concurrently.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_mem_array.sv | 56 +++++
 rtl/axi_burst_mem_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI burst memory slave: response encodings and
// the state types of the independent write and read channel FSMs.
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Write channel: wait for AW, absorb W beats, present B
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wrState_t;

    // Read channel: wait for AR, stream R beats
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rdState_t;

endpackage

// File: rtl/axi_burst_mem_array.sv
// ---------------------------------------------------------------------------
// axi_burst_mem_array
// Word memory with one byte-enable write port and one registered read port.
//   clk_i     : clock, rising edge
//   rst_ni    : async active-low reset (clears only the read data register)
//   wrEn_i    : write enable for this cycle
//   wrIdx_i   : word index to write
//   wrData_i  : write data
//   wrStrb_i  : byte enables, bit b covers wrData_i[8b+7:8b]
//   rdEn_i    : load the read register from rdIdx_i on this edge
//   rdIdx_i   : word index to read
//   rdData_o  : registered read data, holds while rdEn_i is low
// A read and a write to the same word on the same edge returns the old word.
// ---------------------------------------------------------------------------
module axi_burst_mem_array #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wrEn_i,
    input  logic [DEPTH_LOG2-1:0] wrIdx_i,
    input  logic [31:0]           wrData_i,
    input  logic [3:0]            wrStrb_i,
    input  logic                  rdEn_i,
    input  logic [DEPTH_LOG2-1:0] rdIdx_i,
    output logic [31:0]           rdData_o
);

    localparam int Depth = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [0:Depth-1];
    logic [31:0] rdData_q;

    // Storage itself is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wrStrb_i[b]) begin
                    mem_q[wrIdx_i][8*b +: 8] <= wrData_i[8*b +: 8];
                end
            end
        end
    end

    // The read register only loads on request so a stalled beat stays put
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem_q[rdIdx_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_burst_mem_slave
// AXI4 INCR burst responder over an on-chip word memory. Write and read
// channels are independent FSMs and may run concurrently; each accepts one
// burst at a time.
//   S_AXI_ACLK / S_AXI_ARESETN : clock and async active-low reset
//   AW* / W* / B*              : write address, data and response channels
//   AR* / R*                   : read address and data channels
// Start addresses with any bit set above the memory index are out of range:
// writes are absorbed and answered SLVERR, reads return zero data with SLVERR.
// ---------------------------------------------------------------------------
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH_LOG2   = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IdxW = C_MEM_DEPTH_LOG2;
    localparam logic [IdxW-1:0] IdxOne = 1;

    wrState_t                    wrState_q, wrState_d;
    logic [C_S_AXI_ID_WIDTH-1:0] wrId_q, wrId_d;
    logic [IdxW-1:0]             wrIdx_q, wrIdx_d;
    logic [7:0]                  wrCnt_q, wrCnt_d;
    logic                        wrRangeErr_q, wrRangeErr_d;
    logic                        wrLastErr_q, wrLastErr_d;

    rdState_t                    rdState_q, rdState_d;
    logic [C_S_AXI_ID_WIDTH-1:0] rdId_q, rdId_d;
    logic [IdxW-1:0]             rdIdx_q, rdIdx_d;
    logic [7:0]                  rdCnt_q, rdCnt_d;
    logic                        rdErr_q, rdErr_d;

    logic                        ready_q;

    logic                        awReady, wReady, bValid, arReady, rValid;
    logic                        memWrEn, memRdEn;
    logic [IdxW-1:0]             memRdIdx;
    logic [31:0]                 memRdData;

    // Low address bits select a byte within the word and are not used
    logic                        unusedAddrBits;
    assign unusedAddrBits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Keeps both address channels closed until the first edge after reset
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Write channel state register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wrState_q    <= W_IDLE;
            wrId_q       <= '0;
            wrIdx_q      <= '0;
            wrCnt_q      <= '0;
            wrRangeErr_q <= 1'b0;
            wrLastErr_q  <= 1'b0;
        end else begin
            wrState_q    <= wrState_d;
            wrId_q       <= wrId_d;
            wrIdx_q      <= wrIdx_d;
            wrCnt_q      <= wrCnt_d;
            wrRangeErr_q <= wrRangeErr_d;
            wrLastErr_q  <= wrLastErr_d;
        end
    end

    // Write channel next state. The burst always ends on the beat count; a
    // WLAST that disagrees with the count only flags the response.
    always_comb begin
        wrState_d    = wrState_q;
        wrId_d       = wrId_q;
        wrIdx_d      = wrIdx_q;
        wrCnt_d      = wrCnt_q;
        wrRangeErr_d = wrRangeErr_q;
        wrLastErr_d  = wrLastErr_q;
        awReady      = 1'b0;
        wReady       = 1'b0;
        bValid       = 1'b0;
        memWrEn      = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                awReady = ready_q;
                if (ready_q && S_AXI_AWVALID) begin
                    wrId_d       = S_AXI_AWID;
                    wrIdx_d      = S_AXI_AWADDR[IdxW+1:2];
                    wrCnt_d      = S_AXI_AWLEN;
                    wrRangeErr_d = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IdxW+2];
                    wrLastErr_d  = 1'b0;
                    wrState_d    = W_DATA;
                end
            end
            W_DATA: begin
                wReady = 1'b1;
                if (S_AXI_WVALID) begin
                    memWrEn = !wrRangeErr_q;
                    wrIdx_d = wrIdx_q + IdxOne;
                    wrCnt_d = wrCnt_q - 8'd1;
                    if (S_AXI_WLAST != (wrCnt_q == 8'd0)) begin
                        wrLastErr_d = 1'b1;
                    end
                    if (wrCnt_q == 8'd0) begin
                        wrState_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bValid = 1'b1;
                if (S_AXI_BREADY) begin
                    wrState_d = W_IDLE;
                end
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    // Read channel state register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdState_q <= R_IDLE;
            rdId_q    <= '0;
            rdIdx_q   <= '0;
            rdCnt_q   <= '0;
            rdErr_q   <= 1'b0;
        end else begin
            rdState_q <= rdState_d;
            rdId_q    <= rdId_d;
            rdIdx_q   <= rdIdx_d;
            rdCnt_q   <= rdCnt_d;
            rdErr_q   <= rdErr_d;
        end
    end

    // Read channel next state. The memory is fetched one beat ahead: the AR
    // handshake loads the first word, and each non-final R handshake loads
    // the following word, so data is ready the cycle it is presented.
    always_comb begin
        rdState_d = rdState_q;
        rdId_d    = rdId_q;
        rdIdx_d   = rdIdx_q;
        rdCnt_d   = rdCnt_q;
        rdErr_d   = rdErr_q;
        arReady   = 1'b0;
        rValid    = 1'b0;
        memRdEn   = 1'b0;
        memRdIdx  = rdIdx_q + IdxOne;
        case (rdState_q)
            R_IDLE: begin
                arReady  = ready_q;
                memRdIdx = S_AXI_ARADDR[IdxW+1:2];
                if (ready_q && S_AXI_ARVALID) begin
                    memRdEn   = 1'b1;
                    rdId_d    = S_AXI_ARID;
                    rdIdx_d   = S_AXI_ARADDR[IdxW+1:2];
                    rdCnt_d   = S_AXI_ARLEN;
                    rdErr_d   = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IdxW+2];
                    rdState_d = R_DATA;
                end
            end
            R_DATA: begin
                rValid = 1'b1;
                if (S_AXI_RREADY) begin
                    if (rdCnt_q == 8'd0) begin
                        rdState_d = R_IDLE;
                    end else begin
                        memRdEn = 1'b1;
                        rdIdx_d = rdIdx_q + IdxOne;
                        rdCnt_d = rdCnt_q - 8'd1;
                    end
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    axi_burst_mem_array #(
        .DEPTH_LOG2(C_MEM_DEPTH_LOG2)
    ) u_mem (
        .clk_i    (S_AXI_ACLK),
        .rst_ni   (S_AXI_ARESETN),
        .wrEn_i   (memWrEn),
        .wrIdx_i  (wrIdx_q),
        .wrData_i (S_AXI_WDATA),
        .wrStrb_i (S_AXI_WSTRB),
        .rdEn_i   (memRdEn),
        .rdIdx_i  (memRdIdx),
        .rdData_o (memRdData)
    );

    assign S_AXI_AWREADY = awReady;
    assign S_AXI_WREADY  = wReady;
    assign S_AXI_BVALID  = bValid;
    assign S_AXI_BID     = wrId_q;
    assign S_AXI_BRESP   = (bValid && (wrRangeErr_q || wrLastErr_q)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // Out-of-range reads present zero rather than whatever the alias holds
    assign S_AXI_ARREADY = arReady;
    assign S_AXI_RVALID  = rValid;
    assign S_AXI_RID     = rdId_q;
    assign S_AXI_RDATA   = (rValid && !rdErr_q) ? memRdData : '0;
    assign S_AXI_RRESP   = (rValid && rdErr_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign S_AXI_RLAST   = rValid && (rdCnt_q == 8'd0);

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_mem_slave
// Directed and randomized bursts against a word-array reference model of the
// 256-byte memory. Inputs change and outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem_slave;

    logic        clock;
    logic        aresetN;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int          testCount = 0;
    int          failCount = 0;

    logic [31:0] refMem [0:63];
    logic [31:0] beatData [0:255];
    logic [3:0]  beatStrb [0:255];

    axi_burst_mem_slave dut (
        .S_AXI_ACLK    (clock),
        .S_AXI_ARESETN (aresetN),
        .S_AXI_AWID    (awid),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BID     (bid),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RID     (rid),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    // 100 MHz clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a handshake never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts, asserts, reports
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Model of a completed write burst: in-range bursts update bytes by strobe
    task automatic modelWrite(input logic [31:0] addr, input int len);
        int idx;
        if (addr < 32'h100) begin
            for (int i = 0; i <= len; i++) begin
                idx = (int'(addr[7:2]) + i) % 64;
                for (int b = 0; b < 4; b++) begin
                    if (beatStrb[i][b]) refMem[idx][8*b +: 8] = beatData[i][8*b +: 8];
                end
            end
        end
    endtask

    // Full write burst using beatData/beatStrb. badLast drives WLAST on every
    // beat except the final one. gapPct inserts idle cycles between beats.
    task automatic applyStimulus(input logic [0:0] idIn, input logic [31:0] addr, input int len,
                                 input bit badLast, input int gapPct);
        int waitCycles;
        int hold;
        logic [1:0] expResp;
        expResp = (addr >= 32'h100 || badLast) ? 2'b10 : 2'b00;
        @(negedge clock);
        awid = idIn; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        waitCycles = 0;
        while (awready !== 1'b1 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        checkOutput("aw_accept", 32'(awready), 32'd1);
        if (awready !== 1'b1) begin
            awvalid = 1'b0;
            return;
        end
        @(negedge clock);
        awvalid = 1'b0;
        checkOutput("awready_busy", 32'(awready), 32'd0);
        checkOutput("wready_after_aw", 32'(wready), 32'd1);
        for (int i = 0; i <= len; i++) begin
            if (int'($urandom_range(99)) < gapPct) begin
                wvalid = 1'b0;
                @(negedge clock);
            end
            wvalid = 1'b1;
            wdata  = beatData[i];
            wstrb  = beatStrb[i];
            wlast  = badLast ? (i != len) : (i == len);
            @(negedge clock);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checkOutput("bvalid_after_last", 32'(bvalid), 32'd1);
        hold = int'($urandom_range(2));
        for (int k = 0; k < hold; k++) begin
            bready = 1'b0;
            @(negedge clock);
            checkOutput("bvalid_hold", 32'(bvalid), 32'd1);
        end
        checkOutput("bresp", 32'(bresp), 32'(expResp));
        checkOutput("bid", 32'(bid), 32'(idIn));
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        checkOutput("bvalid_drop", 32'(bvalid), 32'd0);
        checkOutput("awready_reopen", 32'(awready), 32'd1);
        modelWrite(addr, len);
    endtask

    // Full read burst checked beat by beat against refMem. mode 0: RREADY
    // always high, 1: random, 2: the repeating pattern 1,0,0.
    task automatic readBurst(input logic [0:0] idIn, input logic [31:0] addr, input int len, input int mode);
        int waitCycles;
        int c;
        int stalls;
        bit rr;
        logic [31:0] expData;
        logic [1:0]  expResp;
        @(negedge clock);
        arid = idIn; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        waitCycles = 0;
        while (arready !== 1'b1 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        checkOutput("ar_accept", 32'(arready), 32'd1);
        if (arready !== 1'b1) begin
            arvalid = 1'b0;
            return;
        end
        @(negedge clock);
        arvalid = 1'b0;
        checkOutput("arready_busy", 32'(arready), 32'd0);
        c = 0;
        for (int i = 0; i <= len; i++) begin
            expData = (addr < 32'h100) ? refMem[(int'(addr[7:2]) + i) % 64] : 32'd0;
            expResp = (addr < 32'h100) ? 2'b00 : 2'b10;
            stalls = 0;
            rr = 1'b0;
            while (!rr) begin
                checkOutput("rvalid", 32'(rvalid), 32'd1);
                checkOutput("rdata", rdata, expData);
                checkOutput("rresp", 32'(rresp), 32'(expResp));
                checkOutput("rlast", 32'(rlast), 32'(i == len));
                checkOutput("rid", 32'(rid), 32'(idIn));
                case (mode)
                    0:       rr = 1'b1;
                    1:       rr = ($urandom_range(1) == 1) || (stalls >= 6);
                    default: rr = ((c % 3) == 0);
                endcase
                c++;
                stalls++;
                rready = rr;
                @(negedge clock);
            end
        end
        rready = 1'b0;
        checkOutput("rvalid_drop", 32'(rvalid), 32'd0);
        checkOutput("arready_reopen", 32'(arready), 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        int          len;
        aresetN = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset values and ready timing on release
        repeat (3) @(negedge clock);
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_arready", 32'(arready), 32'd0);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_rlast", 32'(rlast), 32'd0);
        checkOutput("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        checkOutput("rst_ids", {30'd0, bid, rid}, 32'd0);
        aresetN = 1'b1;
        #1;
        checkOutput("release_awready_before_edge", 32'(awready), 32'd0);
        @(negedge clock);
        checkOutput("release_awready", 32'(awready), 32'd1);
        checkOutput("release_arready", 32'(arready), 32'd1);

        // Fill the whole memory so every later read has a defined model value
        for (int i = 0; i < 64; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = 4'hF;
        end
        applyStimulus(1'b0, 32'h0, 63, 1'b0, 0);
        readBurst(1'b1, 32'h0, 63, 0);

        // Four-beat burst at 0x10
        for (int i = 0; i < 4; i++) begin
            beatData[i] = 32'hA0 + 32'(i);
            beatStrb[i] = 4'hF;
        end
        applyStimulus(1'b1, 32'h10, 3, 1'b0, 0);
        readBurst(1'b0, 32'h10, 3, 0);

        // Byte strobes on word 0
        beatData[0] = 32'hFFFF_FFFF; beatStrb[0] = 4'hF;
        applyStimulus(1'b0, 32'h0, 0, 1'b0, 0);
        beatData[0] = 32'h0000_0000; beatStrb[0] = 4'h5;
        applyStimulus(1'b0, 32'h0, 0, 1'b0, 0);
        readBurst(1'b0, 32'h0, 0, 0);
        checkOutput("strobe_model_word0", refMem[0], 32'hFF00_FF00);

        // Index wrap from word 62
        readBurst(1'b1, 32'hF8, 3, 0);

        // Out-of-range read and write; the aliased words must stay unchanged
        readBurst(1'b1, 32'h100, 1, 0);
        beatData[0] = $urandom; beatStrb[0] = 4'hF;
        beatData[1] = $urandom; beatStrb[1] = 4'hF;
        applyStimulus(1'b1, 32'h100, 1, 1'b0, 0);
        readBurst(1'b0, 32'h0, 1, 0);

        // Concurrent AW/AR with stalled reads and distinct IDs
        for (int i = 0; i < 6; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = 4'($urandom_range(15));
        end
        fork
            applyStimulus(1'b1, 32'h80, 5, 1'b0, 0);
            readBurst(1'b0, 32'h20, 5, 2);
        join
        fork
            applyStimulus(1'b0, 32'hC0, 2, 1'b0, 30);
            readBurst(1'b1, 32'h80, 5, 2);
        join

        // WLAST misplaced: SLVERR, beat count still ends the burst
        for (int i = 0; i < 3; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = 4'h0;
        end
        applyStimulus(1'b1, 32'h40, 2, 1'b1, 0);
        applyStimulus(1'b0, 32'h40, 0, 1'b1, 0);
        readBurst(1'b1, 32'h40, 2, 1);

        // Longest burst wraps the memory four times
        for (int i = 0; i < 256; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = 4'($urandom_range(15));
        end
        applyStimulus(1'b1, 32'h44, 255, 1'b0, 10);
        readBurst(1'b0, 32'h0, 63, 1);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            len  = int'($urandom_range(15));
            addr = ($urandom_range(7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(255));
            for (int i = 0; i <= len; i++) begin
                beatData[i] = $urandom;
                beatStrb[i] = 4'($urandom_range(15));
            end
            applyStimulus(1'($urandom_range(1)), addr, len, 1'b0, 25);
            addr = ($urandom_range(7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(255));
            readBurst(1'($urandom_range(1)), addr, int'($urandom_range(15)), int'($urandom_range(2)));
        end

        // Reset in the middle of an 8-beat read, on beat 2
        @(negedge clock);
        checkOutput("midrst_arready", 32'(arready), 32'd1);
        arid = 1'b1; araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        rready = 1'b1;
        checkOutput("midrst_beat0", rdata, refMem[0]);
        @(negedge clock);
        checkOutput("midrst_beat1", rdata, refMem[1]);
        aresetN = 1'b0;
        #1;
        checkOutput("midrst_rvalid_async", 32'(rvalid), 32'd0);
        @(negedge clock);
        rready = 1'b0;
        checkOutput("midrst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("midrst_arready_in_reset", 32'(arready), 32'd0);
        aresetN = 1'b1;
        #1;
        checkOutput("midrst_arready_before_edge", 32'(arready), 32'd0);
        @(negedge clock);
        checkOutput("midrst_arready_after_edge", 32'(arready), 32'd1);
        checkOutput("midrst_rvalid_after", 32'(rvalid), 32'd0);
        readBurst(1'b0, 32'h30, 7, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
